out_bcd_display: RTL
====================

Name: out_bcd_display

Overview:
- Downstream consumer of the processor's 32-bit `out0` result bus.
- Watches the bus and converts each new value to packed BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the decimal digits onto one common 7-segment driver with per-digit enables.
- Replaces direct hex viewing of `out0` on the board.

Parameters:
- DATA_W, 32, width of the input value.
- DIGITS, 10, number of decimal digits. Must satisfy DIGITS ≥ ceil(DATA_W·log10(2)); 10 for 32 bits.
- SCAN_DIV, 50000, clk cycles each digit stays enabled. Must be ≥ 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  value to display, driven by processor `out0`.
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  4*DIGITS  last completed conversion; nibble k = decimal digit k, k=0 is the units digit.
- seg  output  7  segments, active-high; bit0=a … bit6=g.
- an  output  DIGITS  digit enables, one-hot, active-high; bit k drives digit k.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; last_val=0; bcd_out=0; busy=0.
  - prescaler=0; digit index=0; seg=0; an=0.
- Converter FSM, states IDLE, SHIFT, LATCH:
  - IDLE: when in_data != last_val on an edge (edge 0): last_val<=in_data, bin shift reg<=in_data, bcd shift reg<=0, count<=0; go to SHIFT; busy=1 from edge 0.
  - SHIFT: each edge does one combined step.
    - Every bcd nibble ≥5 gets +3.
    - Then {bcd,bin} shifts left 1; the bin MSB enters the bcd LSB.
    - count increments; after DATA_W steps (edges 1..DATA_W) go to LATCH.
  - LATCH (edge DATA_W+1): bcd_out<=bcd shift reg, busy<=0, go to IDLE.
  - Latency: bcd_out is valid DATA_W+1 edges after detection (33 for default).
- in_data changes while busy are ignored. On return to IDLE, the next edge compares in_data to last_val and restarts if different, so the final value is always shown. Intermediate values may be skipped.
- in_data equal to last_val triggers no conversion. After reset, in_data=0 never converts and the display shows 0.
- reset low mid-conversion: abort immediately, restore all reset values, partial result discarded.
- Scanner (runs independently of the converter):
  - prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index increments modulo DIGITS (DIGITS-1 → 0).
- Registered display outputs, one-cycle latency from index and bcd_out:
  - an <= one-hot(index).
  - seg <= decode(bcd_out nibble[index]).
  - First nonzero an is 1 (digit 0) on the first edge after reset release.
- Decode (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values 10–15 cannot occur; decode to 00.
- Leading-zero blanking: digit k>0 gives seg=00 if nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked. an still asserts for blanked digits.
- bcd_out changes mid-scan: seg reflects the new value from the next edge; no glitch suppression required.

Test Plan:
- Reset released, in_data=0 for 100 cycles:
  - busy stays 0, bcd_out=0.
  - With SCAN_DIV=4: an cycles 001→002→…→200 (hex), every 4 cycles.
  - seg=3F on digit 0 and 00 on digits 1–9.
- in_data=1234 held:
  - busy rises on edge 0 and falls on edge 33.
  - bcd_out=0x0000001234 at edge 33.
  - Scan shows seg 4=66, 3=4F, 2=5B, 1=06 on digits 0–3; digits 4–9 blank.
- in_data=32'hFFFFFFFF → bcd_out=0x4294967295 after 33 edges; no digit blanked.
- in_data=5, then 99 at edge 10 of the conversion:
  - bcd_out=0x05 at edge 33.
  - New conversion detected at edge 34.
  - bcd_out=0x99 at edge 67.
- in_data=777, reset pulsed low at edge 15:
  - bcd_out=0, busy=0, an=0, seg=0 immediately.
  - After release, 777 is reconverted; bcd_out=0x777 33 edges after detection.
- in_data held at 42 after a completed conversion → no further busy pulses over 200 cycles.

Source files
------------

// File: rtl/out_bcd_display.sv
// Display back-end for the processor's out0 bus: converts each new value to packed BCD with a
// sequential double-dabble engine and scans the digits onto one shared 7-segment driver.
module out_bcd_display #(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 10,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = 4 * DIGITS + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_W-1:0]     last_val;
    logic [DATA_W-1:0]     bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [CNT_W-1:0]      count;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [WORD_W-1:0]     step_word;
    logic                  start;

    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      index;
    logic [DIGITS-1:0]     zero_from;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [6:0]            seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    assign start = (in_data != last_val);

    // ------------------------------------------------------------------ converter FSM
    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CNT_W'(DATA_W - 1)) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left by one.
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            end else begin
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4];
            end
        end
    end

    assign step_word = {bcd_adj, bin_sr} << 1;

    // NOTE: the shift registers are cleared on reset too, so an aborted conversion
    // leaves no partial result behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_val <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            bcd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_val <= in_data;
                        bin_sr   <= in_data;
                        bcd_sr   <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_sr <= step_word[WORD_W-1:DATA_W];
                    bin_sr <= step_word[DATA_W-1:0];
                    count  <= count + CNT_W'(1);
                end
                LATCH: begin
                    bcd_out <= bcd_sr;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------ digit scanner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            index     <= '0;
        end else if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            index     <= (index == IDX_W'(DIGITS - 1)) ? '0 : index + IDX_W'(1);
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // zero_from[k] is set when nibbles k..DIGITS-1 are all zero (leading-zero run).
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (bcd_out[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (bcd_out[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (index == IDX_W'(k)) begin
                cur_nib   = bcd_out[4*k +: 4];
                cur_blank = (k != 0) && zero_from[k];
            end
        end
        seg_next = cur_blank ? 7'h00 : seg_decode(cur_nib);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= '0;
            an  <= '0;
        end else begin
            seg <= seg_next;
            an  <= DIGITS'(1) << index;
        end
    end

endmodule
